// File: rtl/max7219_time_chain.sv
// MAX7219 daisy-chain driver for the IRIG-B time display.
// Captures a 6*N_DEV byte time frame into a shadow register, commits it
// atomically to the display register, and periodically streams the full
// configuration plus all eight digits to every chip over the 3-wire bus.
module max7219_time_chain #(
  parameter int N_DEV       = 1,
  parameter int CLK_DIV     = 5,
  parameter int REFRESH_CYC = 5000000,
  parameter int INTENSITY   = 8,
  parameter int BLINK_EN    = 1
) (
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic [7:0] pi_data,
  input  logic       flag,
  input  logic       pps,
  output logic       CS,
  output logic       CLK,
  output logic       Din,
  output logic       busy,
  output logic       frame_done
);

  localparam int NB    = 6 * N_DEV;
  localparam int SW    = 16 * N_DEV;
  localparam int CNT_W = $clog2(NB);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(SW);
  localparam int REF_W = $clog2(REFRESH_CYC);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NB - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SW - 1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYC - 1);
  localparam logic [3:0]       WORD_LAST = 4'd12;
  localparam logic [7:0]       INT_DATA  = 8'(INTENSITY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_HOLD,
    S_GAP
  } state_t;

  state_t state, state_next;

  logic [4*NB-1:0]  shadow;
  logic [4*NB-1:0]  shadow_next;
  logic [4*NB-1:0]  disp;
  logic [CNT_W-1:0] cap_cnt;
  logic             cap_full;
  logic [3:0]       unused_hi;

  logic [REF_W-1:0] ref_cnt;
  logic             tick;
  logic             pending;
  logic             kick;
  logic             start;

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [3:0]       word_idx;
  logic [SW-1:0]    shreg;
  logic [SW-1:0]    word_data;
  logic             blank;
  logic             div_done;
  logic             bit_last;
  logic             word_last;

  // The upper nibble of each time byte carries no digit information.
  assign unused_hi   = pi_data[7:4];
  assign shadow_next = {shadow[4*NB-5:0], pi_data[3:0]};

  assign tick      = (ref_cnt == REF_LAST);
  assign start     = kick | pending | tick;
  assign div_done  = (div_cnt == DIV_LAST);
  assign bit_last  = (bit_cnt == BIT_LAST);
  assign word_last = (word_idx == WORD_LAST);

  // Byte capture: shift into the shadow, commit whole frames only.
  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      shadow   <= '0;
      disp     <= {NB{4'hA}};
      cap_cnt  <= '0;
      cap_full <= 1'b0;
    end else if (!flag) begin
      cap_cnt  <= '0;
      cap_full <= 1'b0;
    end else if (!cap_full) begin
      shadow <= shadow_next;
      if (cap_cnt == CNT_LAST) begin
        disp     <= shadow_next;
        cap_full <= 1'b1;
        cap_cnt  <= '0;
      end else begin
        cap_cnt <= cap_cnt + 1'b1;
      end
    end
  end

  // Refresh timer with a single pending slot; the first frame follows reset.
  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      ref_cnt <= '0;
      pending <= 1'b0;
      kick    <= 1'b1;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + 1'b1;
      if (state == S_IDLE && start) begin
        pending <= 1'b0;
        kick    <= 1'b0;
      end else if (tick && state != S_IDLE) begin
        pending <= 1'b1;
      end
    end
  end

  // Build the current 16*N_DEV-bit transaction, farthest chip in the top bits.
  always_comb begin
    logic [3:0] addr;
    logic [7:0] cfg_data;
    logic [7:0] data;
    logic [2:0] slot;
    logic       is_digit;
    logic       dash;
    addr      = 4'h0;
    cfg_data  = 8'h00;
    data      = 8'h00;
    slot      = 3'd0;
    is_digit  = 1'b0;
    dash      = 1'b0;
    word_data = '0;
    case (word_idx)
      4'd0:    begin addr = 4'hF; cfg_data = 8'h00;    end
      4'd1:    begin addr = 4'h9; cfg_data = 8'hFF;    end
      4'd2:    begin addr = 4'hA; cfg_data = INT_DATA; end
      4'd3:    begin addr = 4'hB; cfg_data = 8'h07;    end
      4'd4:    begin addr = 4'hC; cfg_data = 8'h01;    end
      default: begin addr = word_idx - 4'd4; is_digit = 1'b1; end
    endcase
    case (addr)
      4'd8:    slot = 3'd5;
      4'd7:    slot = 3'd4;
      4'd5:    slot = 3'd3;
      4'd4:    slot = 3'd2;
      4'd2:    slot = 3'd1;
      4'd1:    slot = 3'd0;
      default: dash = 1'b1;
    endcase
    for (int c = 0; c < N_DEV; c++) begin
      data = cfg_data;
      if (is_digit) begin
        if (blank)
          data = 8'h0F;
        else if (dash)
          data = 8'h0A;
        else
          data = {4'h0, disp[4*(6*c + int'(slot)) +: 4]};
      end
      word_data[16*c +: 16] = {4'h0, addr, data};
    end
  end

  // Serial FSM state register.
  always_ff @(posedge sys_clk) begin
    if (!_rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Serial FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_LOAD;
      S_LOAD:     state_next = S_SETUP;
      S_SETUP:    if (div_done) state_next = S_SHIFT_LO;
      S_SHIFT_LO: if (div_done) state_next = S_SHIFT_HI;
      S_SHIFT_HI: if (div_done) state_next = bit_last ? S_HOLD : S_SHIFT_LO;
      S_HOLD:     if (div_done) state_next = S_GAP;
      S_GAP:      if (div_done) state_next = word_last ? S_IDLE : S_LOAD;
      default:    state_next = S_IDLE;
    endcase
  end

  // Sequencer datapath: dwell counters, shift register and registered pins.
  always_ff @(posedge sys_clk) begin
    if (!_rst) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      word_idx   <= 4'd0;
      shreg      <= '0;
      blank      <= 1'b0;
      CS         <= 1'b1;
      CLK        <= 1'b0;
      Din        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= (state_next != state || state == S_IDLE) ? '0 : div_cnt + 1'b1;
      busy       <= (state_next != S_IDLE);
      frame_done <= (state == S_GAP) && div_done && word_last;
      CS         <= !(state_next inside {S_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_HOLD});
      CLK        <= (state_next == S_SHIFT_HI);
      case (state)
        S_IDLE: begin
          if (start) begin
            word_idx <= 4'd0;
            blank    <= (BLINK_EN != 0) && pps;
          end
        end
        S_LOAD: begin
          shreg   <= word_data;
          Din     <= word_data[SW-1];
          bit_cnt <= '0;
        end
        S_SHIFT_HI: begin
          if (div_done && !bit_last) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= {shreg[SW-2:0], 1'b0};
            Din     <= shreg[SW-2];
          end
        end
        S_GAP: begin
          if (div_done && !word_last)
            word_idx <= word_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max7219_time_chain.sv
// Self-checking bench for max7219_time_chain: a two-chip instance for
// content/timing/blink/reset and a one-chip, fast-refresh, no-blink
// instance for back-to-back frames.
module tb_max7219_time_chain;

  localparam int ND_A = 2, DIV_A = 2, REF_A = 3000, INT_A = 5;
  localparam int ND_B = 1, DIV_B = 1, REF_B = 100,  INT_B = 8;
  localparam int WORD_A = 1 + DIV_A * (32 * ND_A + 3);
  localparam int WORD_B = 1 + DIV_B * (32 * ND_B + 3);

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [7:0] pi_data_a, pi_data_b;
  logic       flag_a, flag_b, pps;
  logic       cs_a, clk_a, din_a, busy_a, done_a;
  logic       cs_b, clk_b, din_b, busy_b, done_b;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  tx[16];
  int          md[2][4][9];
  int          dmap[6] = '{8, 7, 5, 4, 2, 1};

  logic [63:0] sh_a = '0, sh_b = '0;
  int          nb_a = 0, nb_b = 0;
  logic [63:0] qa_bits[$], qb_bits[$];
  int          qa_n[$], qb_n[$];

  always #5 sys_clk = ~sys_clk;

  max7219_time_chain #(.N_DEV(ND_A), .CLK_DIV(DIV_A), .REFRESH_CYC(REF_A),
                       .INTENSITY(INT_A), .BLINK_EN(1)) dut_a (
    .sys_clk(sys_clk), ._rst(rst_n), .pi_data(pi_data_a), .flag(flag_a),
    .pps(pps), .CS(cs_a), .CLK(clk_a), .Din(din_a), .busy(busy_a),
    .frame_done(done_a));

  max7219_time_chain #(.N_DEV(ND_B), .CLK_DIV(DIV_B), .REFRESH_CYC(REF_B),
                       .INTENSITY(INT_B), .BLINK_EN(0)) dut_b (
    .sys_clk(sys_clk), ._rst(rst_n), .pi_data(pi_data_b), .flag(flag_b),
    .pps(pps), .CS(cs_b), .CLK(clk_b), .Din(din_b), .busy(busy_b),
    .frame_done(done_b));

  // Collect each CS-low transaction of chain A as it appears on the pins.
  always @(posedge clk_a or posedge cs_a) begin
    if (cs_a) begin
      if (nb_a > 0) begin
        qa_bits.push_back(sh_a);
        qa_n.push_back(nb_a);
      end
      nb_a = 0;
      sh_a = '0;
    end else begin
      sh_a = {sh_a[62:0], din_a};
      nb_a++;
    end
  end

  // Collect each CS-low transaction of chain B.
  always @(posedge clk_b or posedge cs_b) begin
    if (cs_b) begin
      if (nb_b > 0) begin
        qb_bits.push_back(sh_b);
        qb_n.push_back(nb_b);
      end
      nb_b = 0;
      sh_b = '0;
    end else begin
      sh_b = {sh_b[62:0], din_b};
      nb_b++;
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive n bytes from tx on consecutive cycles, then drop flag for a cycle.
  task automatic applyStimulus(input int n, input bit to_b);
    for (int i = 0; i < n; i++) begin
      if (to_b) begin pi_data_b = tx[i]; flag_b = 1'b1; end
      else      begin pi_data_a = tx[i]; flag_a = 1'b1; end
      step();
    end
    flag_a = 1'b0;
    flag_b = 1'b0;
    step();
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++)
      tx[i] = {4'($urandom), 4'($urandom_range(0, 9))};
  endtask

  task automatic modelReset();
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < 4; c++)
        for (int d = 0; d < 9; d++)
          md[w][c][d] = 10;
  endtask

  // Only a complete frame changes the display; extra bytes are ignored.
  task automatic modelCapture(input int which, input int n);
    int nd;
    nd = (which != 0) ? ND_B : ND_A;
    if (n >= 6 * nd)
      for (int k = 0; k < 6 * nd; k++)
        md[which][nd - 1 - k / 6][dmap[k % 6]] = int'(tx[k][3:0]);
  endtask

  function automatic logic [63:0] expWord(input int which, input int idx, input bit blank);
    int          nd;
    logic [63:0] w;
    logic [7:0]  a, d;
    nd = (which != 0) ? ND_B : ND_A;
    w  = '0;
    for (int c = nd - 1; c >= 0; c--) begin
      case (idx)
        0: begin a = 8'h0F; d = 8'h00; end
        1: begin a = 8'h09; d = 8'hFF; end
        2: begin a = 8'h0A; d = 8'((which != 0) ? INT_B : INT_A); end
        3: begin a = 8'h0B; d = 8'h07; end
        4: begin a = 8'h0C; d = 8'h01; end
        default: begin
          a = 8'(idx - 4);
          d = blank ? 8'h0F : 8'(md[which][c][idx - 4]);
        end
      endcase
      w = (w << 16) | {48'h0, a, d};
    end
    return w;
  endfunction

  task automatic checkFrame(input int which, input bit blank, input string nm);
    int          sz, nd;
    logic [63:0] w;
    int          n;
    nd = (which != 0) ? ND_B : ND_A;
    sz = (which != 0) ? qb_n.size() : qa_n.size();
    checkOutput($sformatf("%s_word_count", nm), 64'(sz), 64'd13);
    for (int i = 0; i < ((sz < 13) ? sz : 13); i++) begin
      if (which != 0) begin w = qb_bits[i]; n = qb_n[i]; end
      else            begin w = qa_bits[i]; n = qa_n[i]; end
      checkOutput($sformatf("%s_word%0d", nm, i + 1), w, expWord(which, i, blank));
      checkOutput($sformatf("%s_bits%0d", nm, i + 1), 64'(n), 64'(16 * nd));
    end
  endtask

  task automatic waitDone(input int which, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      step();
      if ((which != 0) ? done_b : done_a) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({nm, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic clearQueues();
    qa_bits.delete(); qa_n.delete();
    qb_bits.delete(); qb_n.delete();
  endtask

  // Directed sequence with randomized digit data.
  initial begin
    int cyc;
    bit ok;
    rst_n = 1'b0; flag_a = 1'b0; flag_b = 1'b0;
    pi_data_a = 8'h00; pi_data_b = 8'h00; pps = 1'b0;
    modelReset();
    repeat (4) step();
    checkOutput("reset_outs_a", 64'({cs_a, clk_a, din_a, busy_a, done_a}), 64'b10000);
    checkOutput("reset_outs_b", 64'({cs_b, clk_b, din_b, busy_b, done_b}), 64'b10000);

    // Reset release: one LOAD cycle, then CS low; whole frame timing.
    clearQueues();
    rst_n = 1'b1;
    step();
    checkOutput("load_cycle_busy_cs", 64'({busy_a, cs_a}), 64'b11);
    step();
    checkOutput("cs_fall", 64'(cs_a), 64'd0);
    cyc = 2;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (!busy_a) break;
      cyc++;
    end
    checkOutput("frame_len_a", 64'(cyc), 64'(13 * WORD_A));
    checkOutput("frame_done_at_busy_fall", 64'(done_a), 64'd1);
    checkFrame(0, 1'b0, "boot");
    step();
    checkOutput("frame_done_width", 64'(done_a), 64'd0);

    // Capture and display.
    clearQueues();
    fillRandom(12);
    applyStimulus(12, 1'b0);
    modelCapture(0, 12);
    waitDone(0, "cap");
    checkFrame(0, 1'b0, "cap");

    // Aborted capture, then a full frame with flag held past the end.
    clearQueues();
    fillRandom(3);
    applyStimulus(3, 1'b0);
    fillRandom(15);
    applyStimulus(15, 1'b0);
    modelCapture(0, 15);
    waitDone(0, "abort");
    checkFrame(0, 1'b0, "abort");

    // PPS high at frame start blanks every digit on chain A.
    clearQueues();
    pps = 1'b1;
    waitDone(0, "blink");
    checkFrame(0, 1'b1, "blink");

    // Chain B ignores pps and runs frames back to back.
    fillRandom(6);
    applyStimulus(6, 1'b1);
    modelCapture(1, 6);
    waitDone(1, "b_pre");
    clearQueues();
    waitDone(1, "b");
    checkFrame(1, 1'b0, "noblink_b");
    checkOutput("b_idle_cycle", 64'(busy_b), 64'd0);
    step();
    checkOutput("b_back_to_back", 64'(busy_b), 64'd1);
    cyc = 1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (!busy_b) break;
      cyc++;
    end
    checkOutput("frame_len_b", 64'(cyc), 64'(13 * WORD_B));
    pps = 1'b0;

    // Reset in the middle of a word on chain A.
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (busy_a) begin ok = 1'b1; break; end
    end
    checkOutput("busy_before_reset", 64'(ok), 64'd1);
    repeat (60) step();
    rst_n = 1'b0;
    step();
    checkOutput("mid_reset_outs_a", 64'({cs_a, clk_a, din_a, busy_a, done_a}), 64'b10000);
    repeat (3) step();
    clearQueues();
    modelReset();
    rst_n = 1'b1;
    waitDone(0, "post_reset");
    checkFrame(0, 1'b0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
